psx_mem_arbiter: RTL and testbench
==================================

Name: psx_mem_arbiter

Overview:
- Two-client request arbiter directly upstream of the PSX-to-DDR bridge; drives the bridge's single command port.
- Client 0 is the GPU and client 1 is the CPU/DMA path. Each client has a one-entry holding slot.
- Selects one pending request, issues it as a single-cycle command when the bridge is not busy, and returns read data to the client that issued the read.

Parameters:
- STARVE_LIMIT, 4, consecutive client-0 grants allowed while client 1 is pending before client 1 is forced (range 1..15).

Ports:
- i_clk  in  1  clock
- i_nRst  in  1  async active-low reset
- i_req0 / i_req1  in  1  client request pulse; legal only while that client's o_busy is 0
- i_write0 / i_write1  in  1  0=read, 1=write
- i_size0 / i_size1  in  2  0=8B, 1=32B, 2=4B
- i_adr0 / i_adr1  in  15  32-byte block address
- i_subAdr0 / i_subAdr1  in  3  4-byte sub-address
- i_mask0 / i_mask1  in  16  16-bit write mask
- i_data0 / i_data1  in  256  write data
- o_busy0 / o_busy1  out  1  slot occupied / read outstanding
- o_dataValid0 / o_dataValid1  out  1  read-data pulse
- o_data0 / o_data1  out  256  read data
- o_command  out  1  bridge command strobe
- o_writeElseRead  out  1  to bridge
- o_commandSize  out  2  to bridge
- o_targetAddr  out  15  to bridge
- o_subAddr  out  3  to bridge
- o_writeMask  out  16  to bridge
- o_dataClient  out  256  to bridge
- i_busyBridge  in  1  bridge busy
- i_dataValidBridge  in  1  bridge read-complete pulse
- i_dataBridge  in  256  bridge read data

Behaviour:
- Reset (async, i_nRst=0): both slots empty, state IDLE, starve counter 0, last-grant flag 0. o_command, o_busyN, o_dataValidN and o_dataN are all 0. Bridge field outputs are 0.
- Capture: i_reqN at edge T loads slot N (write flag, size, address, sub-address, mask, data) and sets pendN. o_busyN=1 from T+1. The slot is eligible to issue at T+1 at the earliest.
- States are IDLE and WAIT_READ.
- IDLE: o_command=1 combinationally when (pend0|pend1) & !i_busyBridge. The bridge field outputs are muxed from the winning slot during that cycle; when o_command=0 they hold the last-granted slot's fields.
- On a grant edge:
  - pend of the winning slot clears.
  - Write grant: o_busyN drops the next cycle; state stays IDLE. The bridge's registered busy blocks reissue.
  - Read grant: owner register is set to N; state goes to WAIT_READ; o_busyN stays 1.
- WAIT_READ:
  - o_command=0.
  - On i_dataValidBridge: o_dataOwner is loaded with i_dataBridge at that edge. o_dataValidOwner pulses for exactly 1 cycle after it (registered, 1-cycle latency). Owner busy clears the same edge; state returns to IDLE.
  - o_dataN holds its value until the next read completion for N.
- i_dataValidBridge outside WAIT_READ is ignored.
- Arbitration when only one slot is pending: that slot wins. Arbitration when both are pending (default build):
  - Client 0 wins unless starveCnt == STARVE_LIMIT, in which case client 1 wins.
  - starveCnt increments on each client-0 grant while pend1=1, saturating at STARVE_LIMIT.
  - starveCnt clears on any client-1 grant.
- At most one bridge command per IDLE cycle. Back-to-back writes issue whenever the bridge drops busy.
- A request arriving at a busy client is a protocol violation: it is ignored and the slot is not overwritten.
- Reset mid-transaction discards slots and any outstanding read. No late o_dataValid is produced; the bridge is reset by the same i_nRst.

Optional Feature:
- ARB_ROUND_ROBIN_EN defined: when both slots are pending, the slot not granted last wins (the last-grant flag toggles on each grant). starveCnt is absent and STARVE_LIMIT is unused.
- Undefined: fixed priority with the starvation guard described above.

Test Plan:
- Client-0 32B read, adr=0x0123, bridge idle, bridge returns 0xA5..A5 after 6 cycles:
  - o_command at T+1 with o_targetAddr=0x0123 and o_commandSize=1.
  - o_dataValid0 for 1 cycle with o_data0=0xA5..A5; o_busy0 clears.
  - o_dataValid1 stays 0.
- Both clients issue a write in the same cycle, bridge idle:
  - Client 0 is granted first.
  - Client 1 is granted on the first cycle i_busyBridge=0 afterwards.
  - o_writeMask matches each slot's mask.
- Client 0 requests continuously with client 1 pending, STARVE_LIMIT=4: exactly 4 client-0 grants, then 1 client-1 grant, then the counter restarts.
- Read outstanding for client 1 while client 0 posts a write: no o_command until i_dataValidBridge; client-0 write issues the cycle after the return to IDLE.
- i_nRst pulsed low while in WAIT_READ with both slots full: all outputs are 0 immediately (asynchronously); no o_dataValid pulses after reset release.
- With ARB_ROUND_ROBIN_EN defined and both clients requesting continuously: grants alternate 0,1,0,1.

Source files
------------

// File: rtl/psx_mem_arbiter.sv
// Two-client (GPU=0, CPU/DMA=1) request arbiter feeding the PSX-to-DDR bridge command port.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority with a starvation guard.
module psx_mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic         i_clk,
  input  logic         i_nRst,
  input  logic         i_req0,
  input  logic         i_write0,
  input  logic [1:0]   i_size0,
  input  logic [14:0]  i_adr0,
  input  logic [2:0]   i_subAdr0,
  input  logic [15:0]  i_mask0,
  input  logic [255:0] i_data0,
  input  logic         i_req1,
  input  logic         i_write1,
  input  logic [1:0]   i_size1,
  input  logic [14:0]  i_adr1,
  input  logic [2:0]   i_subAdr1,
  input  logic [15:0]  i_mask1,
  input  logic [255:0] i_data1,
  output logic         o_busy0,
  output logic         o_busy1,
  output logic         o_dataValid0,
  output logic         o_dataValid1,
  output logic [255:0] o_data0,
  output logic [255:0] o_data1,
  output logic         o_command,
  output logic         o_writeElseRead,
  output logic [1:0]   o_commandSize,
  output logic [14:0]  o_targetAddr,
  output logic [2:0]   o_subAddr,
  output logic [15:0]  o_writeMask,
  output logic [255:0] o_dataClient,
  input  logic         i_busyBridge,
  input  logic         i_dataValidBridge,
  input  logic [255:0] i_dataBridge
);

  typedef enum logic {IDLE = 1'b0, WAIT_READ = 1'b1} state_t;

  state_t       state;
  logic [1:0]   pend;
  logic [1:0]   slotWr;
  logic [1:0]   slotSize [2];
  logic [14:0]  slotAdr  [2];
  logic [2:0]   slotSub  [2];
  logic [15:0]  slotMask [2];
  logic [255:0] slotData [2];
  logic         owner;
  logic         lastGrant;
  logic         win;
  logic         grant;
  logic         sel;

`ifndef ARB_ROUND_ROBIN_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  logic [3:0] starveCnt;
`endif

  // Handshake: a client may pulse i_reqN only while o_busyN is 0; o_busyN stays high
  // from the capture edge until a write is granted or a read's data has returned.
  assign o_busy0 = pend[0] | ((state == WAIT_READ) & ~owner);
  assign o_busy1 = pend[1] | ((state == WAIT_READ) &  owner);

  always_comb begin
    win = 1'b0;
    if (pend[0] && pend[1]) begin
`ifdef ARB_ROUND_ROBIN_EN
      win = ~lastGrant;
`else
      win = (starveCnt == LIMIT);
`endif
    end else begin
      win = pend[1];
    end
  end

  assign grant     = (state == IDLE) & (|pend) & ~i_busyBridge;
  assign o_command = grant;

  // Outside a grant cycle the bridge fields keep showing the last-granted slot.
  assign sel             = grant ? win : lastGrant;
  assign o_writeElseRead = slotWr[sel];
  assign o_commandSize   = slotSize[sel];
  assign o_targetAddr    = slotAdr[sel];
  assign o_subAddr       = slotSub[sel];
  assign o_writeMask     = slotMask[sel];
  assign o_dataClient    = slotData[sel];

  always_ff @(posedge i_clk or negedge i_nRst) begin
    if (!i_nRst) begin
      state        <= IDLE;
      pend         <= 2'b00;
      slotWr       <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        slotSize[i] <= '0;
        slotAdr[i]  <= '0;
        slotSub[i]  <= '0;
        slotMask[i] <= '0;
        slotData[i] <= '0;
      end
      owner        <= 1'b0;
      lastGrant    <= 1'b0;
      o_dataValid0 <= 1'b0;
      o_dataValid1 <= 1'b0;
      o_data0      <= '0;
      o_data1      <= '0;
`ifndef ARB_ROUND_ROBIN_EN
      starveCnt    <= '0;
`endif
    end else begin
      o_dataValid0 <= 1'b0;
      o_dataValid1 <= 1'b0;

      // A busy slot is never granted the same edge it captures, so set/clear of pend never collide.
      if (i_req0 && !o_busy0) begin
        pend[0]     <= 1'b1;
        slotWr[0]   <= i_write0;
        slotSize[0] <= i_size0;
        slotAdr[0]  <= i_adr0;
        slotSub[0]  <= i_subAdr0;
        slotMask[0] <= i_mask0;
        slotData[0] <= i_data0;
      end
      if (i_req1 && !o_busy1) begin
        pend[1]     <= 1'b1;
        slotWr[1]   <= i_write1;
        slotSize[1] <= i_size1;
        slotAdr[1]  <= i_adr1;
        slotSub[1]  <= i_subAdr1;
        slotMask[1] <= i_mask1;
        slotData[1] <= i_data1;
      end

      if (grant) begin
        pend[win] <= 1'b0;
        lastGrant <= win;
        if (!slotWr[win]) begin
          owner <= win;
          state <= WAIT_READ;
        end
`ifndef ARB_ROUND_ROBIN_EN
        if (win) begin
          starveCnt <= '0;
        end else if (pend[1] && starveCnt != LIMIT) begin
          starveCnt <= starveCnt + 4'd1;
        end
`endif
      end

      if (state == WAIT_READ && i_dataValidBridge) begin
        state <= IDLE;
        if (owner) begin
          o_data1      <= i_dataBridge;
          o_dataValid1 <= 1'b1;
        end else begin
          o_data0      <= i_dataBridge;
          o_dataValid0 <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_psx_mem_arbiter.sv
// Directed bench for psx_mem_arbiter: read return, simultaneous writes, starvation guard,
// read-blocks-write ordering and asynchronous reset mid-read.
module tb_psx_mem_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit rrBuild = 1'b1;
`else
  localparam bit rrBuild = 1'b0;
`endif

  logic         i_clk;
  logic         i_nRst;
  logic         i_req0, i_req1;
  logic         i_write0, i_write1;
  logic [1:0]   i_size0, i_size1;
  logic [14:0]  i_adr0, i_adr1;
  logic [2:0]   i_subAdr0, i_subAdr1;
  logic [15:0]  i_mask0, i_mask1;
  logic [255:0] i_data0, i_data1;
  logic         o_busy0, o_busy1;
  logic         o_dataValid0, o_dataValid1;
  logic [255:0] o_data0, o_data1;
  logic         o_command;
  logic         o_writeElseRead;
  logic [1:0]   o_commandSize;
  logic [14:0]  o_targetAddr;
  logic [2:0]   o_subAddr;
  logic [15:0]  o_writeMask;
  logic [255:0] o_dataClient;
  logic         i_busyBridge;
  logic         i_dataValidBridge;
  logic [255:0] i_dataBridge;

  psx_mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .i_clk(i_clk), .i_nRst(i_nRst),
    .i_req0(i_req0), .i_write0(i_write0), .i_size0(i_size0), .i_adr0(i_adr0),
    .i_subAdr0(i_subAdr0), .i_mask0(i_mask0), .i_data0(i_data0),
    .i_req1(i_req1), .i_write1(i_write1), .i_size1(i_size1), .i_adr1(i_adr1),
    .i_subAdr1(i_subAdr1), .i_mask1(i_mask1), .i_data1(i_data1),
    .o_busy0(o_busy0), .o_busy1(o_busy1),
    .o_dataValid0(o_dataValid0), .o_dataValid1(o_dataValid1),
    .o_data0(o_data0), .o_data1(o_data1),
    .o_command(o_command), .o_writeElseRead(o_writeElseRead),
    .o_commandSize(o_commandSize), .o_targetAddr(o_targetAddr),
    .o_subAddr(o_subAddr), .o_writeMask(o_writeMask), .o_dataClient(o_dataClient),
    .i_busyBridge(i_busyBridge), .i_dataValidBridge(i_dataValidBridge),
    .i_dataBridge(i_dataBridge)
  );

  // Clock and reset
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  int nTests = 0;
  int nFail  = 0;
  logic [255:0] expQ [$];

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Drivers: inputs change 1 time unit after the rising edge, outputs sampled on the falling edge.
  task automatic nextCycle();
    @(posedge i_clk);
    #1;
    i_req0 = 1'b0;
    i_req1 = 1'b0;
    i_dataValidBridge = 1'b0;
  endtask

  task automatic midCycle();
    @(negedge i_clk);
  endtask

  task automatic postReq(input bit client, input bit wr, input logic [1:0] sz,
                         input logic [14:0] adr, input logic [15:0] mask);
    if (client) begin
      i_req1 = 1'b1; i_write1 = wr; i_size1 = sz; i_adr1 = adr;
      i_subAdr1 = 3'd5; i_mask1 = mask; i_data1 = {16{mask}};
    end else begin
      i_req0 = 1'b1; i_write0 = wr; i_size0 = sz; i_adr0 = adr;
      i_subAdr0 = 3'd2; i_mask0 = mask; i_data0 = {16{mask}};
    end
  endtask

  logic [14:0] firstAdr, secondAdr;
  logic [15:0] firstMask, secondMask;
  int brCnt;
  bit cmdSeen;
  int grants;

  initial begin
    i_nRst = 1'b0;
    i_req0 = 1'b0; i_write0 = 1'b0; i_size0 = '0; i_adr0 = '0; i_subAdr0 = '0; i_mask0 = '0; i_data0 = '0;
    i_req1 = 1'b0; i_write1 = 1'b0; i_size1 = '0; i_adr1 = '0; i_subAdr1 = '0; i_mask1 = '0; i_data1 = '0;
    i_busyBridge = 1'b0; i_dataValidBridge = 1'b0; i_dataBridge = '0;

    // Reset state
    repeat (2) midCycle();
    check("rst_command", o_command, 0);
    check("rst_busy", {o_busy0, o_busy1}, 0);
    check("rst_valid", {o_dataValid0, o_dataValid1}, 0);
    check("rst_data0", o_data0, 0);
    check("rst_addr", o_targetAddr, 0);
    check("rst_mask", o_writeMask, 0);
    i_nRst = 1'b1;

    // Client-0 32B read, data returned after 6 cycles
    nextCycle();
    postReq(1'b0, 1'b0, 2'd1, 15'h0123, 16'h0);
    nextCycle();
    midCycle();
    check("rd0_command", o_command, 1);
    check("rd0_addr", o_targetAddr, 15'h0123);
    check("rd0_size", o_commandSize, 2'd1);
    check("rd0_wr", o_writeElseRead, 0);
    check("rd0_busy", o_busy0, 1);
    nextCycle();
    i_busyBridge = 1'b1;
    for (int i = 0; i < 5; i++) begin
      midCycle();
      check("rd0_wait_cmd", {o_command, o_dataValid0, o_busy0}, 3'b001);
      nextCycle();
    end
    i_busyBridge = 1'b0;
    i_dataValidBridge = 1'b1;
    i_dataBridge = {32{8'hA5}};
    nextCycle();
    midCycle();
    check("rd0_valid", o_dataValid0, 1);
    check("rd0_data", o_data0, {32{8'hA5}});
    check("rd0_busy_clr", o_busy0, 0);
    check("rd0_valid1", o_dataValid1, 0);
    nextCycle();
    midCycle();
    check("rd0_valid_pulse", o_dataValid0, 0);
    check("rd0_data_hold", o_data0, {32{8'hA5}});

    // Simultaneous writes; round-robin favours client 1 here since client 0 won last
    firstAdr   = rrBuild ? 15'h0020 : 15'h0010;
    secondAdr  = rrBuild ? 15'h0010 : 15'h0020;
    firstMask  = rrBuild ? 16'hF00F : 16'h00FF;
    secondMask = rrBuild ? 16'h00FF : 16'hF00F;
    nextCycle();
    postReq(1'b0, 1'b1, 2'd2, 15'h0010, 16'h00FF);
    postReq(1'b1, 1'b1, 2'd0, 15'h0020, 16'hF00F);
    nextCycle();
    midCycle();
    check("ww_cmd1", o_command, 1);
    check("ww_addr1", o_targetAddr, firstAdr);
    check("ww_mask1", o_writeMask, firstMask);
    check("ww_wr1", o_writeElseRead, 1);
    nextCycle();
    i_busyBridge = 1'b1;
    midCycle();
    check("ww_blocked", o_command, 0);
    check("ww_busy_after1", {o_busy0, o_busy1}, rrBuild ? 2'b10 : 2'b01);
    nextCycle();
    nextCycle();
    i_busyBridge = 1'b0;
    midCycle();
    check("ww_cmd2", o_command, 1);
    check("ww_addr2", o_targetAddr, secondAdr);
    check("ww_mask2", o_writeMask, secondMask);
    nextCycle();
    i_busyBridge = 1'b1;
    midCycle();
    check("ww_idle", {o_command, o_busy0, o_busy1}, 0);
    check("ww_hold_addr", o_targetAddr, secondAdr);
    nextCycle();
    i_busyBridge = 1'b0;
    midCycle();
    check("ww_no_reissue", o_command, 0);

    // Continuous writes from both clients with a bridge that stays busy 2 cycles per command
    for (int i = 0; i < 10; i++) begin
      if (rrBuild) expQ.push_back((i % 2 == 0) ? 256'd1 : 256'd0);
      else         expQ.push_back((i % 5 == 4) ? 256'd1 : 256'd0);
    end
    brCnt = 0;
    cmdSeen = 1'b0;
    grants = 0;
    for (int cyc = 0; cyc < 80 && grants < 10; cyc++) begin
      nextCycle();
      if (cmdSeen) brCnt = 2;
      else if (brCnt > 0) brCnt--;
      i_busyBridge = (brCnt != 0);
      if (!o_busy0) postReq(1'b0, 1'b1, 2'd1, 15'h0100 + 15'(cyc), 16'h1111);
      if (!o_busy1) postReq(1'b1, 1'b1, 2'd1, 15'h7F00, 16'h2222);
      midCycle();
      cmdSeen = o_command;
      if (o_command) begin
        check($sformatf("starve_grant%0d", grants), (o_targetAddr == 15'h7F00), expQ.pop_front());
        grants++;
      end
    end
    check("starve_grants_seen", grants, 10);
    for (int cyc = 0; cyc < 10; cyc++) begin
      nextCycle();
      if (cmdSeen) brCnt = 2;
      else if (brCnt > 0) brCnt--;
      i_busyBridge = (brCnt != 0);
      midCycle();
      cmdSeen = o_command;
    end
    check("starve_drained", {o_busy0, o_busy1}, 0);
    nextCycle();
    i_busyBridge = 1'b0;

    // Client-1 read outstanding blocks a client-0 write; a request at busy client 1 is dropped
    postReq(1'b1, 1'b0, 2'd0, 15'h0055, 16'h0);
    nextCycle();
    midCycle();
    check("rw_cmd_rd", o_command, 1);
    check("rw_addr_rd", o_targetAddr, 15'h0055);
    nextCycle();
    postReq(1'b0, 1'b1, 2'd1, 15'h0066, 16'h1234);
    postReq(1'b1, 1'b1, 2'd1, 15'h0044, 16'hFFFF);
    nextCycle();
    for (int i = 0; i < 3; i++) begin
      midCycle();
      check("rw_wait", {o_command, o_busy0, o_busy1}, 3'b011);
      nextCycle();
    end
    i_dataValidBridge = 1'b1;
    i_dataBridge = {8{32'h3C3C_5AA5}};
    nextCycle();
    midCycle();
    check("rw_valid1", {o_dataValid1, o_dataValid0}, 2'b10);
    check("rw_data1", o_data1, {8{32'h3C3C_5AA5}});
    check("rw_busy1", o_busy1, 0);
    check("rw_cmd_wr", o_command, 1);
    check("rw_addr_wr", o_targetAddr, 15'h0066);
    check("rw_mask_wr", o_writeMask, 16'h1234);
    nextCycle();
    i_busyBridge = 1'b1;
    midCycle();
    check("rw_valid_pulse", o_dataValid1, 0);
    check("rw_busy0", o_busy0, 0);
    nextCycle();
    i_busyBridge = 1'b0;
    midCycle();
    check("rw_dropped_req", {o_command, o_busy1}, 0);

    // Asynchronous reset while WAIT_READ with both slots occupied
    nextCycle();
    postReq(1'b0, 1'b0, 2'd2, 15'h0011, 16'h0);
    nextCycle();
    midCycle();
    check("ar_cmd", o_command, 1);
    nextCycle();
    postReq(1'b1, 1'b1, 2'd1, 15'h0022, 16'hABCD);
    nextCycle();
    midCycle();
    check("ar_both_busy", {o_command, o_busy0, o_busy1}, 3'b011);
    #1;
    i_nRst = 1'b0;
    #1;
    check("ar_command", o_command, 0);
    check("ar_busy", {o_busy0, o_busy1}, 0);
    check("ar_valid", {o_dataValid0, o_dataValid1}, 0);
    check("ar_data0", o_data0, 0);
    check("ar_data1", o_data1, 0);
    check("ar_fields", {o_writeElseRead, o_commandSize, o_targetAddr, o_subAddr, o_writeMask}, 0);
    check("ar_dataClient", o_dataClient, 0);
    nextCycle();
    i_nRst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      midCycle();
      check("ar_quiet", {o_dataValid0, o_dataValid1, o_command, o_busy0, o_busy1}, 0);
      nextCycle();
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

  // Overall time guard
  initial begin
    #200000;
    $display("[TB] FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
